// File: rtl/lcd_disp_pkg.sv
// rtl/lcd_disp_pkg.sv - shared state encoding, ASCII constants and width helper for the LCD field refresher
package lcd_disp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CONVERT,
    EMIT,
    NEXT
  } dispState_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Ceiling log2 with a floor of 1 so single-entry counters still get a bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
// start loads the value; done is high during the final step, result valid the cycle after.
module bin2bcd_seq
  import lcd_disp_pkg::*;
#(
  parameter int VAL_W  = 64,
  parameter int DIGITS = 14
) (
  input  logic                  simClock,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [VAL_W-1:0]      value,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CNT_W = clog2(VAL_W);

  logic [VAL_W-1:0]    shiftReg;
  logic [4*DIGITS-1:0] adjusted;
  logic [CNT_W-1:0]    stepCnt;
  logic                running;

  assign done = running && (stepCnt == CNT_W'(VAL_W - 1));

  always_comb begin
    adjusted = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adjusted[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // The top digit's msb after adjustment is what leaves the register on the shift.
  always_ff @(posedge simClock or negedge rstN) begin
    if (!rstN) begin
      shiftReg <= '0;
      bcd      <= '0;
      ovf      <= 1'b0;
      stepCnt  <= '0;
      running  <= 1'b0;
    end else if (start) begin
      shiftReg <= value;
      bcd      <= '0;
      ovf      <= 1'b0;
      stepCnt  <= '0;
      running  <= 1'b1;
    end else if (running) begin
      shiftReg <= shiftReg << 1;
      bcd      <= {adjusted[4*DIGITS-2:0], shiftReg[VAL_W-1]};
      ovf      <= ovf | adjusted[4*DIGITS-1];
      stepCnt  <= stepCnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_field_refresher.sv
// rtl/lcd_field_refresher.sv - periodic decimal field renderer feeding the LCD character-write port
// Optional LCD_LEADING_BLANK_EN: leading zero digits are emitted as spaces.
module lcd_field_refresher
  import lcd_disp_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int VAL_W       = 64,
  parameter int DIGITS      = 14,
  parameter int LINE_STRIDE = 16,
  parameter int ADDR_W      = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    CLK_50MHZ,
  input  logic                    RST_N,
  input  logic [NUM_CH*VAL_W-1:0] CH_VALUE,
  output logic                    LCD_WE,
  output logic [ADDR_W-1:0]       LCD_WRITE_ADDR,
  output logic [7:0]              LCD_WRITE_DATA,
  output logic                    BUSY,
  output logic                    FRAME_DONE,
  output logic [NUM_CH-1:0]       SAT
);

  localparam int CH_W  = clog2(NUM_CH);
  localparam int DIG_W = clog2(DIGITS);
  localparam int TMR_W = clog2(REFRESH_DIV);
`ifdef LCD_LEADING_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  dispState_e          state;
  logic [CH_W-1:0]     chIdx;
  logic [DIG_W-1:0]    digIdx;
  logic [TMR_W-1:0]    timer;
  logic [ADDR_W-1:0]   fieldBase;
  logic                pending;
  logic                seenDigit;
  logic                tick;
  logic                lastDigit;
  logic                lastCh;
  logic                convStart;
  logic                convDone;
  logic                convOvf;
  logic [4*DIGITS-1:0] convBcd;
  logic [VAL_W-1:0]    chSlice;
  logic [3:0]          curDigit;
  logic [7:0]          emitChar;

  assign tick      = (timer == TMR_W'(REFRESH_DIV - 1));
  assign lastDigit = (digIdx == DIG_W'(DIGITS - 1));
  assign lastCh    = (chIdx == CH_W'(NUM_CH - 1));
  assign convStart = (state == LATCH);
  assign BUSY      = (state != IDLE);
  assign chSlice   = CH_VALUE[int'(chIdx)*VAL_W +: VAL_W];

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) converter (
    .simClock (CLK_50MHZ),
    .rstN     (RST_N),
    .start    (convStart),
    .value    (chSlice),
    .done     (convDone),
    .bcd      (convBcd),
    .ovf      (convOvf)
  );

  // Character i = 0 is the most significant digit of the packed BCD bus.
  always_comb begin
    curDigit = convBcd[4*(DIGITS-1-int'(digIdx)) +: 4];
    emitChar = ASCII_ZERO + {4'h0, curDigit};
    if (convOvf)
      emitChar = ASCII_NINE;
    else if (BLANK_EN && !seenDigit && (curDigit == 4'd0) && !lastDigit)
      emitChar = ASCII_SPACE;
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      chIdx          <= '0;
      digIdx         <= '0;
      timer          <= '0;
      fieldBase      <= '0;
      pending        <= 1'b0;
      seenDigit      <= 1'b0;
      LCD_WE         <= 1'b0;
      LCD_WRITE_ADDR <= '0;
      LCD_WRITE_DATA <= '0;
      FRAME_DONE     <= 1'b0;
      SAT            <= '0;
    end else begin
      timer      <= tick ? '0 : timer + 1'b1;
      FRAME_DONE <= 1'b0;
      if (tick && state != IDLE) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (tick || pending) begin
            pending <= 1'b0;
            state   <= LATCH;
          end
        end
        LATCH: begin
          fieldBase <= ADDR_W'(int'(chIdx) * LINE_STRIDE);
          digIdx    <= '0;
          seenDigit <= 1'b0;
          state     <= CONVERT;
        end
        CONVERT: begin
          if (convDone) state <= EMIT;
        end
        EMIT: begin
          LCD_WE         <= 1'b1;
          LCD_WRITE_ADDR <= fieldBase + ADDR_W'(digIdx);
          LCD_WRITE_DATA <= emitChar;
          SAT[chIdx]     <= convOvf;
          seenDigit      <= seenDigit | (curDigit != 4'd0);
          if (lastDigit) state <= NEXT;
          else           digIdx <= digIdx + 1'b1;
        end
        NEXT: begin
          LCD_WE <= 1'b0;
          if (lastCh) begin
            FRAME_DONE <= 1'b1;
            chIdx      <= '0;
            state      <= IDLE;
          end else begin
            chIdx <= chIdx + 1'b1;
            state <= LATCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_field_refresher.sv
// tb/tb_lcd_field_refresher.sv - randomized self-checking bench against a decimal-rendering reference model
module tb_lcd_field_refresher;

  localparam int NUM_CH      = 2;
  localparam int VAL_W       = 64;
  localparam int DIGITS      = 14;
  localparam int LINE_STRIDE = 16;
  localparam int ADDR_W      = 8;
  localparam int REFRESH_DIV = 100;
  localparam int CH_LEN      = VAL_W + DIGITS + 2;
  localparam int FRAME_LEN   = NUM_CH * CH_LEN;
  localparam int CH1_LATCH   = 1 + CH_LEN;
  localparam int NUM_FRAMES  = 14;

  logic                    simClock = 1'b0;
  logic                    rstN;
  logic [NUM_CH*VAL_W-1:0] chValue;
  logic                    lcdWe;
  logic [ADDR_W-1:0]       lcdAddr;
  logic [7:0]              lcdData;
  logic                    busy;
  logic                    frameDone;
  logic [NUM_CH-1:0]       sat;

  int                vecCnt = 0;
  int                errCnt = 0;
  logic [7:0]        lcdMem [256];
  longint unsigned   curVal [NUM_CH];
  longint unsigned   plan   [5][NUM_CH];

  always #10 simClock = ~simClock;

  lcd_field_refresher #(
    .NUM_CH      (NUM_CH),
    .VAL_W       (VAL_W),
    .DIGITS      (DIGITS),
    .LINE_STRIDE (LINE_STRIDE),
    .ADDR_W      (ADDR_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .CLK_50MHZ      (simClock),
    .RST_N          (rstN),
    .CH_VALUE       (chValue),
    .LCD_WE         (lcdWe),
    .LCD_WRITE_ADDR (lcdAddr),
    .LCD_WRITE_DATA (lcdData),
    .BUSY           (busy),
    .FRAME_DONE     (frameDone),
    .SAT            (sat)
  );

  task automatic checkVal(input string tag, input longint unsigned obs, input longint unsigned exp);
    vecCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] expChar(input longint unsigned v, input int i);
    longint unsigned place = pow10(DIGITS - 1 - i);
    if (v >= pow10(DIGITS)) return 8'h39;
`ifdef LCD_LEADING_BLANK_EN
    if (i != DIGITS - 1 && v < place) return 8'h20;
`endif
    return 8'h30 + 8'((v / place) % 10);
  endfunction

  function automatic longint unsigned toggleVal(input int k);
    return 64'd3141592653 * longint'(k) + 64'd17;
  endfunction

  function automatic longint unsigned randVal();
    longint unsigned v = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0:       return v;
      1:       return v % pow10(DIGITS);
      default: return longint'($urandom_range(0, 999));
    endcase
  endfunction

  task automatic applyVals(input longint unsigned v0, input longint unsigned v1);
    curVal[0] = v0;
    curVal[1] = v1;
    chValue   = {v1, v0};
  endtask

  // Watches one frame at negedges; returns at the FRAME_DONE negedge or after the abortAt-th write.
  task automatic collectFrame(input int abortAt, input bit toggle, output int doneCycle,
                              output int firstWe, output int nWrites, output int busyLow,
                              output bit timedOut);
    for (int a = 0; a < 256; a++) lcdMem[a] = 8'h00;
    doneCycle = 0; firstWe = 0; nWrites = 0; busyLow = 0; timedOut = 1'b1;
    for (int k = 1; k <= 4 * FRAME_LEN; k++) begin
      @(negedge simClock);
      if (toggle) chValue[2*VAL_W-1:VAL_W] = toggleVal(k);
      if (lcdWe) begin
        if (nWrites == 0) begin
          firstWe = k;
          checkVal("first_write_addr", lcdAddr, 0);
        end
        nWrites++;
        lcdMem[lcdAddr] = lcdData;
        if (!busy) busyLow++;
        if (abortAt > 0 && nWrites == abortAt) begin
          rstN = 1'b0;
          #1;
          checkVal("we_drop_on_reset", lcdWe, 0);
          checkVal("outs_zero_on_reset", {lcdWe, lcdAddr, lcdData, busy, frameDone, sat}, 0);
          timedOut = 1'b0;
          return;
        end
      end
      if (frameDone) begin
        doneCycle = k;
        timedOut  = 1'b0;
        return;
      end
    end
  endtask

  task automatic checkFrame();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < DIGITS; i++)
        checkVal($sformatf("ch%0d_char%0d", c, i), lcdMem[c*LINE_STRIDE+i], expChar(curVal[c], i));
      checkVal($sformatf("sat%0d", c), sat[c], curVal[c] >= pow10(DIGITS));
    end
  endtask

  task automatic runFrame(input bit afterReset, input bit toggle);
    int doneCycle, firstWe, nWrites, busyLow;
    bit timedOut;
    collectFrame(0, toggle, doneCycle, firstWe, nWrites, busyLow, timedOut);
    if (toggle) curVal[1] = toggleVal(CH1_LATCH);
    if (timedOut) begin
      checkVal("frame_timeout", 1, 0);
      return;
    end
    checkFrame();
    checkVal("writes_per_frame", nWrites, NUM_CH * DIGITS);
    checkVal("busy_low_during_we", busyLow, 0);
    if (afterReset) checkVal("quiet_after_reset", firstWe > REFRESH_DIV, 1);
    else            checkVal("frame_period", doneCycle, FRAME_LEN + 1);
  endtask

  initial begin
    int doneCycle, firstWe, nWrites, busyLow;
    bit timedOut;
    plan[0] = '{64'd0, 64'd12345};
    plan[1] = '{64'd99999999999999, 64'd700};
    plan[2] = '{64'd100000000000000, 64'd0};
    plan[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    plan[4] = '{64'd42, 64'd0};

    rstN = 1'b0;
    applyVals(plan[0][0], plan[0][1]);
    repeat (3) @(negedge simClock);
    checkVal("reset_outputs", {lcdWe, lcdAddr, lcdData, busy, frameDone, sat}, 0);
    rstN = 1'b1;

    for (int f = 0; f < NUM_FRAMES; f++) begin
      runFrame(f == 0, f == 4);
      if (f + 1 < 5) applyVals(plan[f+1][0], plan[f+1][1]);
      else           applyVals(randVal(), randVal());
    end

    collectFrame(5, 1'b0, doneCycle, firstWe, nWrites, busyLow, timedOut);
    if (timedOut) checkVal("abort_timeout", 1, 0);
    repeat (3) @(negedge simClock);
    rstN = 1'b1;
    runFrame(1'b1, 1'b0);
    applyVals(randVal(), 64'd12345);
    runFrame(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
